wt_store_responder: RTL

- Memory-side responder for the write-through dcache store path.
- Accepts store requests tagged with a transaction ID and buffers them in an in-order queue.
- Performs each store on a single-port SRAM-style write interface with fixed write latency.
- Returns one acknowledge per store, carrying the original TID, in acceptance order.
- Sits between the dcache memory port and the L2 or memory model in cached regions.

---
 rtl/wt_store_responder.sv | 134 +++++++++++++
 1 files changed

// File: rtl/wt_store_responder.sv
// Memory-side store responder: queues tagged stores, writes them to a
// fixed-latency SRAM port in order, and returns one in-order TID acknowledge per store.
module wt_store_responder #(
  parameter int unsigned AddrWidth    = 64,
  parameter int unsigned DataWidth    = 64,
  parameter int unsigned TidWidth     = 2,
  parameter int unsigned QueueDepth   = 8,
  parameter int unsigned WriteLatency = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             req_valid_i,
  output logic                             req_ready_o,
  input  logic [AddrWidth-1:0]             req_addr_i,
  input  logic [DataWidth-1:0]             req_data_i,
  input  logic [DataWidth/8-1:0]           req_be_i,
  input  logic [TidWidth-1:0]              req_tid_i,
  output logic                             mem_we_o,
  output logic [AddrWidth-1:0]             mem_addr_o,
  output logic [DataWidth-1:0]             mem_wdata_o,
  output logic [DataWidth/8-1:0]           mem_be_o,
  input  logic                             mem_gnt_i,
  output logic                             ack_valid_o,
  input  logic                             ack_ready_i,
  output logic [TidWidth-1:0]              ack_tid_o,
  output logic [$clog2(QueueDepth+1)-1:0]  outstanding_o,
  output logic                             busy_o
);

  localparam int unsigned BeWidth = DataWidth / 8;
  localparam int unsigned PtrW    = (QueueDepth > 1) ? $clog2(QueueDepth) : 1;
  localparam int unsigned CntW    = $clog2(QueueDepth + 1);
  localparam int unsigned LatW    = (WriteLatency > 1) ? $clog2(WriteLatency) : 1;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] data;
    logic [BeWidth-1:0]   be;
    logic [TidWidth-1:0]  tid;
  } entry_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_e;

  state_e          state_q, state_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [LatW-1:0] lat_q, lat_d;
  logic            ready_q, ready_d;
  entry_t          mem_q [QueueDepth];
  entry_t          head;
  logic            accept, pop;

  assign accept = req_valid_i && ready_q;
  assign pop    = (state_q == ACK) && ack_ready_i;
  assign head   = mem_q[rd_ptr_q];

  // Queue storage needs no reset: every read is gated by the FSM state.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= '{addr: req_addr_i, data: req_data_i, be: req_be_i, tid: req_tid_i};
    end
  end

  // Pointer and occupancy bookkeeping.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)    rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({accept, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    // Ready tracks the registered count, so a pop while full frees space next cycle.
    ready_d = (count_d != CntW'(QueueDepth));
  end

  // Next-state logic; IDLE looks at the same-cycle accept to reach ISSUE one cycle after it.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    unique case (state_q)
      IDLE: begin
        if ((count_q != '0) || accept) state_d = ISSUE;
      end
      ISSUE: begin
        if (mem_gnt_i) begin
          lat_d   = LatW'(WriteLatency - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (lat_q == '0) state_d = ACK;
        else             lat_d   = lat_q - LatW'(1);
      end
      ACK: begin
        if (pop) state_d = (count_d != '0) ? ISSUE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      lat_q    <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      lat_q    <= lat_d;
      ready_q  <= ready_d;
    end
  end

  // Outputs decode directly from registered state; buses read zero outside their phase.
  assign mem_we_o      = (state_q == ISSUE);
  assign mem_addr_o    = mem_we_o ? head.addr : '0;
  assign mem_wdata_o   = mem_we_o ? head.data : '0;
  assign mem_be_o      = mem_we_o ? head.be   : '0;
  assign ack_valid_o   = (state_q == ACK);
  assign ack_tid_o     = ack_valid_o ? head.tid : '0;
  assign outstanding_o = count_q;
  assign busy_o        = (count_q != '0);
  assign req_ready_o   = ready_q;

endmodule
